// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and sequencer types: opcodes, ALU codes, immediate and
// write-back selects, FSM states and the instruction classifier.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_LUI  = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_OP_IMM,
    CLS_OP,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic     imem_req;
    logic     ir_we;
    logic     pc_we;
    logic     pc_sel;
    logic     reg_wen;
    logic     a_sel;
    logic     b_sel;
    logic     br_un;
    imm_sel_e imm_sel;
    alu_op_e  alu_control;
    logic     dmem_req;
    logic     mem_rw;
    wb_sel_e  wb_sel;
    logic     illegal;
  } seq_ctrl_t;

  // Reserved funct3 values of branch/load/store are folded into CLS_ILLEGAL.
  function automatic instr_class_e classify(input logic [6:0] opcode,
                                            input logic [2:0] funct3);
    instr_class_e cls;
    case (opcode)
      OPC_LOAD:   cls = (funct3 inside {3'b011, 3'b110, 3'b111}) ? CLS_ILLEGAL : CLS_LOAD;
      OPC_STORE:  cls = (funct3 >= 3'b011) ? CLS_ILLEGAL : CLS_STORE;
      OPC_BRANCH: cls = (funct3 inside {3'b010, 3'b011}) ? CLS_ILLEGAL : CLS_BRANCH;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_OP:     cls = CLS_OP;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Maps (opcode, funct3, instr[30]) to the ALU operation code. Non-arithmetic
// opcodes use add for address / target computation; LUI passes the immediate.
module alu_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output alu_op_e    alu_control
);

  logic is_reg;

  assign is_reg = (opcode == OPC_OP);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_control = ALU_ADD;
    if (opcode == OPC_LUI) begin
      alu_control = ALU_LUI;
    end else if (is_reg || opcode == OPC_OP_IMM) begin
      // instr[30] selects sub only for register-register; addi has no sub form.
      case (funct3)
        3'b000: alu_control = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_control = ALU_SLL;
        3'b010: alu_control = ALU_SLT;
        3'b011: alu_control = ALU_SLTU;
        3'b100: alu_control = ALU_XOR;
        3'b101: alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_control = ALU_OR;
        3'b111: alu_control = ALU_AND;
        default: alu_control = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ready
// handshakes to instruction and data memory; outputs decode state and instr.
module mc_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic            imem_req,
  output logic            ir_we,
  output logic            pc_we,
  output logic            PCsel,
  output logic            RegWEn,
  output logic            Asel,
  output logic            Bsel,
  output logic            BrUn,
  output logic [2:0]      imm_sel,
  output logic [3:0]      alu_control,
  output logic            dmem_req,
  output logic            MemRW,
  output logic [1:0]      WBsel,
  output logic            illegal,
  output logic [2:0]      state
);

  state_e       state_q, state_d;
  instr_class_e cls;
  alu_op_e      alu_op;
  seq_ctrl_t    ctrl, ctrl_out;
  logic [2:0]   funct3;
  logic         taken;
  logic         dp_a_sel, dp_b_sel;
  imm_sel_e     dp_imm_sel;
  logic         unused_instr;

  assign funct3       = instr[14:12];
  assign cls          = classify(instr[6:0], funct3);
  assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

  alu_decode u_alu_decode (
    .opcode      (instr[6:0]),
    .funct3      (funct3),
    .funct7_b5   (instr[30]),
    .alu_control (alu_op)
  );

  // NOTE: sequential state uses non-blocking assignment; the reset is
  // synchronous and only the state register needs it.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLt;
      3'b101, 3'b111: taken = !BrLt;
      default:        taken = 1'b0;
    endcase
  end

  // Operand selects per class; held unchanged through EXEC, MEM and WB.
  always_comb begin
    dp_a_sel   = 1'b0;
    dp_b_sel   = 1'b1;
    dp_imm_sel = IMM_I;
    case (cls)
      CLS_OP:     dp_b_sel = 1'b0;
      CLS_STORE:  dp_imm_sel = IMM_S;
      CLS_BRANCH: begin dp_a_sel = 1'b1; dp_imm_sel = IMM_B; end
      CLS_LUI:    dp_imm_sel = IMM_U;
      CLS_AUIPC:  begin dp_a_sel = 1'b1; dp_imm_sel = IMM_U; end
      CLS_JAL:    begin dp_a_sel = 1'b1; dp_imm_sel = IMM_J; end
      default:    ;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;

    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      ctrl.a_sel       = dp_a_sel;
      ctrl.b_sel       = dp_b_sel;
      ctrl.imm_sel     = dp_imm_sel;
      ctrl.alu_control = alu_op;
    end

    case (state_q)
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        if (imem_ready) begin
          ctrl.ir_we = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls != CLS_ILLEGAL) begin
          state_d = ST_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          state_d = ST_TRAP;
        end else begin
          ctrl.pc_we = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          ctrl.pc_we  = 1'b1;
          ctrl.pc_sel = taken;
          ctrl.br_un  = funct3[2] & funct3[1];
          state_d     = ST_FETCH;
        end else if (cls inside {CLS_LOAD, CLS_STORE}) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        ctrl.dmem_req = 1'b1;
        ctrl.mem_rw   = (cls == CLS_STORE);
        if (dmem_ready) begin
          if (cls == CLS_STORE) begin
            ctrl.pc_we = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        ctrl.reg_wen = 1'b1;
        ctrl.pc_we   = 1'b1;
        if (cls inside {CLS_JAL, CLS_JALR}) begin
          ctrl.pc_sel = 1'b1;
          ctrl.wb_sel = WB_PC4;
        end else if (cls == CLS_LOAD) begin
          ctrl.wb_sel = WB_MEM;
        end else begin
          ctrl.wb_sel = WB_ALU;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: ctrl.illegal = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset silences every strobe immediately, so an abandoned handshake cannot
  // retire or write anything on the reset edge.
  assign ctrl_out = rst ? '0 : ctrl;

  assign imem_req    = ctrl_out.imem_req;
  assign ir_we       = ctrl_out.ir_we;
  assign pc_we       = ctrl_out.pc_we;
  assign PCsel       = ctrl_out.pc_sel;
  assign RegWEn      = ctrl_out.reg_wen;
  assign Asel        = ctrl_out.a_sel;
  assign Bsel        = ctrl_out.b_sel;
  assign BrUn        = ctrl_out.br_un;
  assign imm_sel     = ctrl_out.imm_sel;
  assign alu_control = ctrl_out.alu_control;
  assign dmem_req    = ctrl_out.dmem_req;
  assign MemRW       = ctrl_out.mem_rw;
  assign WBsel       = ctrl_out.wb_sel;
  assign illegal     = ctrl_out.illegal;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a phase-level reference model builds the
// expected per-cycle output trace of each instruction under random memory waits.
module tb_mc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, BrEq, BrLt;
  logic        imem_req, ir_we, pc_we, PCsel, RegWEn, Asel, Bsel, BrUn;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_control;
  logic        dmem_req, MemRW;
  logic [1:0]  WBsel;
  logic        illegal;
  logic [2:0]  state;

  mc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .BrEq        (BrEq),
    .BrLt        (BrLt),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .PCsel       (PCsel),
    .RegWEn      (RegWEn),
    .Asel        (Asel),
    .Bsel        (Bsel),
    .BrUn        (BrUn),
    .imm_sel     (imm_sel),
    .alu_control (alu_control),
    .dmem_req    (dmem_req),
    .MemRW       (MemRW),
    .WBsel       (WBsel),
    .illegal     (illegal),
    .state       (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_we, pc_we, pc_sel, reg_wen, a_sel, b_sel, br_un;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       dmem_req, mem_rw;
    logic [1:0] wb;
    logic       ill;
  } obs_t;

  typedef struct {
    obs_t exp;
    bit   irdy;
    bit   drdy;
  } step_t;

  obs_t        obs;
  step_t       trace[$];
  logic [31:0] cur_instr = '0;
  bit          cur_beq = 0, cur_blt = 0;
  int          n_checks = 0, n_pass = 0;

  assign obs = {state, imem_req, ir_we, pc_we, PCsel, RegWEn, Asel, Bsel, BrUn,
                imm_sel, alu_control, dmem_req, MemRW, WBsel, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  // One clock cycle: drive on the falling edge, sample 1 ns later.
  task automatic cycle(input bit r, input bit irdy, input bit drdy, output obs_t o);
    @(negedge clk);
    rst        = r;
    instr      = cur_instr;
    imem_ready = irdy;
    dmem_ready = drdy;
    BrEq       = cur_beq;
    BrLt       = cur_blt;
    #1;
    o = obs;
  endtask

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [3:0] tbl [8];
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    tbl = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd2, 4'd3};
    if (op == 7'h37) return 4'hF;
    if (op != 7'h33 && op != 7'h13) return 4'd0;
    if (f3 == 3'd5 && ins[30]) return 4'd8;
    if (f3 == 3'd0 && ins[30] && op == 7'h33) return 4'd1;
    return tbl[f3];
  endfunction

  // Reference model: the instruction's life as a list of phases, each phase a
  // run of cycles with fixed expected outputs.
  task automatic build_trace(input logic [31:0] ins, input int iw, input int dw,
                             input bit beq, input bit blt);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit is_ld = (op == 7'h03), is_st = (op == 7'h23), is_br = (op == 7'h63);
    bit is_opi = (op == 7'h13), is_op = (op == 7'h33), is_lui = (op == 7'h37);
    bit is_aui = (op == 7'h17), is_jal = (op == 7'h6F), is_jalr = (op == 7'h67);
    bit legal;
    obs_t c, o;
    step_t s;
    cur_instr = ins;
    cur_beq   = beq;
    cur_blt   = blt;
    trace.delete();
    legal = is_ld ? !(f3 inside {3'd3, 3'd6, 3'd7}) :
            is_st ? (f3 < 3'd3) :
            is_br ? !(f3 inside {3'd2, 3'd3}) :
            (is_opi | is_op | is_lui | is_aui | is_jal | is_jalr);
    for (int i = 0; i <= iw; i++) begin
      o = blank(3'd0); o.imem_req = 1; o.ir_we = (i == iw);
      s.exp = o; s.irdy = (i == iw); s.drdy = 1'($urandom); trace.push_back(s);
    end
    s.exp = blank(3'd1); s.irdy = 1'($urandom); s.drdy = 1'($urandom); trace.push_back(s);
    if (!legal) begin
      for (int i = 0; i < 3; i++) begin
        o = blank(3'd5); o.ill = 1;
        s.exp = o; s.irdy = 1'($urandom); s.drdy = 1'($urandom); trace.push_back(s);
      end
      return;
    end
    c = '0;
    c.a_sel = is_br | is_aui | is_jal;
    c.b_sel = !is_op;
    c.imm   = is_st ? 3'd1 : is_br ? 3'd2 : (is_lui | is_aui) ? 3'd3 : is_jal ? 3'd4 : 3'd0;
    c.alu   = ref_alu(ins);
    o = c; o.st = 3'd2;
    if (is_br) begin
      o.pc_we  = 1;
      o.br_un  = (f3 == 3'd6 || f3 == 3'd7);
      o.pc_sel = (f3 == 3'd0) ? beq : (f3 == 3'd1) ? !beq :
                 (f3 == 3'd4 || f3 == 3'd6) ? blt : !blt;
    end
    s.exp = o; s.irdy = 1'($urandom); s.drdy = 1'($urandom); trace.push_back(s);
    if (is_br) return;
    if (is_ld || is_st) begin
      for (int j = 0; j <= dw; j++) begin
        o = c; o.st = 3'd3; o.dmem_req = 1; o.mem_rw = is_st;
        o.pc_we = is_st && (j == dw);
        s.exp = o; s.irdy = 1'($urandom); s.drdy = (j == dw); trace.push_back(s);
      end
      if (is_st) return;
    end
    o = c; o.st = 3'd4; o.reg_wen = 1; o.pc_we = 1;
    o.wb     = is_ld ? 2'd0 : (is_jal | is_jalr) ? 2'd2 : 2'd1;
    o.pc_sel = is_jal | is_jalr;
    s.exp = o; s.irdy = 1'($urandom); s.drdy = 1'($urandom); trace.push_back(s);
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] ins = $urandom;
    logic [2:0]  f3  = 3'($urandom);
    case ($urandom_range(0, 8))
      0: begin
        ins[6:0] = 7'h03;
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      1: begin ins[6:0] = 7'h23; f3 = 3'($urandom_range(0, 2)); end
      2: begin
        ins[6:0] = 7'h63;
        while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom);
      end
      3: begin
        ins[6:0] = 7'h13;
        if (f3 == 3'd1) ins[31:25] = 7'd0;
        if (f3 == 3'd5) ins[31:25] = {1'b0, 1'($urandom), 5'd0};
      end
      4: begin
        ins[6:0]   = 7'h33;
        ins[31:25] = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, 1'($urandom), 5'd0} : 7'd0;
      end
      5: ins[6:0] = 7'h37;
      6: ins[6:0] = 7'h17;
      7: ins[6:0] = 7'h6F;
      default: begin ins[6:0] = 7'h67; f3 = 3'd0; end
    endcase
    ins[14:12] = f3;
    return ins;
  endfunction

  task automatic test_reset();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1'($urandom), 1'($urandom), o);
      e = blank(3'd0);
      n_checks++;
      if (o !== e) $display("FAIL reset_hold cyc%0d: got %h want %h", i, o, e);
      else n_pass++;
    end
    cycle(0, 0, 0, o);
    e = blank(3'd0); e.imem_req = 1;
    n_checks++;
    if (o !== e) $display("FAIL reset_release: got %h want %h", o, e);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] prog [6];
    int          dws  [6];
    bit          beqs [6], blts [6];
    obs_t        o;
    prog = '{32'h002081B3, 32'h0000A103, 32'h00208463, 32'h00208463, 32'h0020F463, 32'h4020D093};
    dws  = '{0, 3, 0, 0, 0, 0};
    beqs = '{0, 0, 1, 0, 0, 0};
    blts = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      build_trace(prog[k], 0, dws[k], beqs[k], blts[k]);
      foreach (trace[i]) begin
        cycle(0, trace[i].irdy, trace[i].drdy, o);
        n_checks++;
        if (o !== trace[i].exp)
          $display("FAIL directed %h cyc%0d: got %h want %h", prog[k], i, o, trace[i].exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [31:0] ins;
    for (int k = 0; k < 60; k++) begin
      ins = rand_legal();
      build_trace(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      foreach (trace[i]) begin
        cycle(0, trace[i].irdy, trace[i].drdy, o);
        n_checks++;
        if (o !== trace[i].exp)
          $display("FAIL random %h cyc%0d: got %h want %h", ins, i, o, trace[i].exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [5];
    obs_t        o, e;
    bad = '{32'h0000007F, 32'h00002063, 32'h00007003, 32'h00003023, 32'h00000000};
    for (int k = 0; k < 5; k++) begin
      build_trace(bad[k], $urandom_range(0, 2), 0, 1'($urandom), 1'($urandom));
      foreach (trace[i]) begin
        cycle(0, trace[i].irdy, trace[i].drdy, o);
        n_checks++;
        if (o !== trace[i].exp)
          $display("FAIL illegal %h cyc%0d: got %h want %h", bad[k], i, o, trace[i].exp);
        else n_pass++;
      end
      cycle(1, 1, 1, o);
      e = blank(3'd5);
      n_checks++;
      if (o !== e) $display("FAIL trap_in_reset %h: got %h want %h", bad[k], o, e);
      else n_pass++;
      cycle(0, 0, 0, o);
      e = blank(3'd0); e.imem_req = 1;
      n_checks++;
      if (o !== e) $display("FAIL trap_exit %h: got %h want %h", bad[k], o, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_store();
    obs_t o, e;
    build_trace(32'h0020A023, 0, 6, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, trace[i].irdy, trace[i].drdy, o);
      n_checks++;
      if (o !== trace[i].exp)
        $display("FAIL store_pre_reset cyc%0d: got %h want %h", i, o, trace[i].exp);
      else n_pass++;
    end
    cycle(1, 0, 1, o);
    e = blank(3'd3);
    n_checks++;
    if (o !== e) $display("FAIL store_reset_cycle: got %h want %h", o, e);
    else n_pass++;
    cycle(0, 0, 1, o);
    e = blank(3'd0); e.imem_req = 1;
    n_checks++;
    if (o !== e) $display("FAIL store_after_reset: got %h want %h", o, e);
    else n_pass++;
  endtask

  initial begin
    rst = 1; instr = '0; imem_ready = 0; dmem_ready = 0; BrEq = 0; BrLt = 0;
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_reset_mid_store();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
